// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller: address-mux selects, grant codes,
// exception causes and FSM states.
package mem_access_ctrl_pkg;

  localparam logic [2:0] SEL_PC  = 3'b000;
  localparam logic [2:0] SEL_ALU = 3'b001;
  localparam logic [2:0] SEL_253 = 3'b010;
  localparam logic [2:0] SEL_254 = 3'b011;
  localparam logic [2:0] SEL_255 = 3'b100;
  localparam logic [2:0] SEL_A   = 3'b101;
  localparam logic [2:0] SEL_B   = 3'b110;

  localparam logic [1:0] GNT_FETCH = 2'b00;
  localparam logic [1:0] GNT_DATA  = 2'b01;
  localparam logic [1:0] GNT_REG   = 2'b10;
  localparam logic [1:0] GNT_EXC   = 2'b11;

  localparam logic [1:0] CAUSE_253 = 2'b00;
  localparam logic [1:0] CAUSE_254 = 2'b01;
  localparam logic [1:0] CAUSE_255 = 2'b10;
  localparam logic [1:0] CAUSE_BAD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StCapture
  } state_e;

  // The illegal cause still reads vector 255 so the handler sees something defined.
  function automatic logic [2:0] exc_sel(input logic [1:0] cause);
    case (cause)
      CAUSE_253: return SEL_253;
      CAUSE_254: return SEL_254;
      default:   return SEL_255;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Fixed-priority requester encoder: exc > data > reg > fetch.
module mem_req_arbiter
  import mem_access_ctrl_pkg::*;
(
  input  logic       req_fetch_i,
  input  logic       req_data_i,
  input  logic       data_we_i,
  input  logic       req_reg_i,
  input  logic       reg_sel_i,
  input  logic       reg_we_i,
  input  logic       req_exc_i,
  input  logic [1:0] exc_cause_i,
  output logic       valid_o,
  output logic [1:0] grant_o,
  output logic [2:0] sel_o,
  output logic       we_o,
  output logic       bad_o
);

  always_comb begin
    valid_o = 1'b1;
    grant_o = GNT_FETCH;
    sel_o   = SEL_PC;
    we_o    = 1'b0;
    bad_o   = 1'b0;
    if (req_exc_i) begin
      grant_o = GNT_EXC;
      sel_o   = exc_sel(exc_cause_i);
      bad_o   = (exc_cause_i == CAUSE_BAD);
    end else if (req_data_i) begin
      grant_o = GNT_DATA;
      sel_o   = SEL_ALU;
      we_o    = data_we_i;
    end else if (req_reg_i) begin
      grant_o = GNT_REG;
      sel_o   = reg_sel_i ? SEL_B : SEL_A;
      we_o    = reg_we_i;
    end else if (!req_fetch_i) begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access sequencer: arbitrates requesters in IDLE, drives the address-mux
// select and write/load strobes through ACCESS, WAIT and CAPTURE.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_fetch_i,
  input  logic       req_data_i,
  input  logic       data_we_i,
  input  logic       req_reg_i,
  input  logic       reg_sel_i,
  input  logic       reg_we_i,
  input  logic       req_exc_i,
  input  logic [1:0] exc_cause_i,
  output logic [2:0] mem_adrs_src_o,
  output logic       mem_wr_o,
  output logic       ir_wr_o,
  output logic       mdr_wr_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] grant_o,
  output logic       exc_bad_o
);

  localparam int unsigned CntW = 3;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [2:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;

  logic              arb_valid;
  logic [1:0]        arb_grant;
  logic [2:0]        arb_sel;
  logic              arb_we;
  logic              arb_bad;

  mem_req_arbiter u_arbiter (
    .req_fetch_i (req_fetch_i),
    .req_data_i  (req_data_i),
    .data_we_i   (data_we_i),
    .req_reg_i   (req_reg_i),
    .reg_sel_i   (reg_sel_i),
    .reg_we_i    (reg_we_i),
    .req_exc_i   (req_exc_i),
    .exc_cause_i (exc_cause_i),
    .valid_o     (arb_valid),
    .grant_o     (arb_grant),
    .sel_o       (arb_sel),
    .we_o        (arb_we),
    .bad_o       (arb_bad)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gnt_d          = gnt_q;
    sel_d          = sel_q;
    we_d           = we_q;
    bad_d          = bad_q;
    mem_adrs_src_o = SEL_PC;
    mem_wr_o       = 1'b0;
    ir_wr_o        = 1'b0;
    mdr_wr_o       = 1'b0;
    done_o         = 1'b0;
    exc_bad_o      = 1'b0;
    busy_o         = 1'b1;
    grant_o        = gnt_q;
    unique case (state_q)
      StIdle: begin
        busy_o  = 1'b0;
        grant_o = GNT_FETCH;
        if (arb_valid) begin
          gnt_d   = arb_grant;
          sel_d   = arb_sel;
          we_d    = arb_we;
          bad_d   = arb_bad;
          state_d = StAccess;
        end
      end
      StAccess: begin
        mem_adrs_src_o = sel_q;
        mem_wr_o       = we_q;
        if (we_q || MEM_LAT == 1) begin
          state_d = StCapture;
        end else begin
          state_d = StWait;
          cnt_d   = CntW'(MEM_LAT - 2);
        end
      end
      StWait: begin
        mem_adrs_src_o = sel_q;
        if (cnt_q == '0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCapture: begin
        mem_adrs_src_o = sel_q;
        done_o         = 1'b1;
        exc_bad_o      = bad_q;
        if (!we_q) begin
          ir_wr_o  = (gnt_q == GNT_FETCH);
          mdr_wr_o = (gnt_q != GNT_FETCH);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_LAT 2 and 4) driven by directed and random
// request patterns, checked cycle by cycle against a transaction-level reference model.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst       [2];
  logic       req_fetch [2];
  logic       req_data  [2];
  logic       data_we   [2];
  logic       req_reg   [2];
  logic       reg_sel   [2];
  logic       reg_we    [2];
  logic       req_exc   [2];
  logic [1:0] exc_cause [2];
  logic [2:0] sel_o     [2];
  logic       mem_wr_o  [2];
  logic       ir_wr_o   [2];
  logic       mdr_wr_o  [2];
  logic       busy_o    [2];
  logic       done_o    [2];
  logic [1:0] grant_o   [2];
  logic       bad_o     [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(2)) dut0 (
    .clk_i          (clk),
    .reset_i        (rst[0]),
    .req_fetch_i    (req_fetch[0]),
    .req_data_i     (req_data[0]),
    .data_we_i      (data_we[0]),
    .req_reg_i      (req_reg[0]),
    .reg_sel_i      (reg_sel[0]),
    .reg_we_i       (reg_we[0]),
    .req_exc_i      (req_exc[0]),
    .exc_cause_i    (exc_cause[0]),
    .mem_adrs_src_o (sel_o[0]),
    .mem_wr_o       (mem_wr_o[0]),
    .ir_wr_o        (ir_wr_o[0]),
    .mdr_wr_o       (mdr_wr_o[0]),
    .busy_o         (busy_o[0]),
    .done_o         (done_o[0]),
    .grant_o        (grant_o[0]),
    .exc_bad_o      (bad_o[0])
  );

  mem_access_ctrl #(.MEM_LAT(4)) dut1 (
    .clk_i          (clk),
    .reset_i        (rst[1]),
    .req_fetch_i    (req_fetch[1]),
    .req_data_i     (req_data[1]),
    .data_we_i      (data_we[1]),
    .req_reg_i      (req_reg[1]),
    .reg_sel_i      (reg_sel[1]),
    .reg_we_i       (reg_we[1]),
    .req_exc_i      (req_exc[1]),
    .exc_cause_i    (exc_cause[1]),
    .mem_adrs_src_o (sel_o[1]),
    .mem_wr_o       (mem_wr_o[1]),
    .ir_wr_o        (ir_wr_o[1]),
    .mdr_wr_o       (mdr_wr_o[1]),
    .busy_o         (busy_o[1]),
    .done_o         (done_o[1]),
    .grant_o        (grant_o[1]),
    .exc_bad_o      (bad_o[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input int d, input string tag, input logic busy, input logic [1:0] gnt,
                          input logic [2:0] sel, input logic mw, input logic ir,
                          input logic mdr, input logic done, input logic bad);
    chk($sformatf("%s d%0d busy", tag, d), {7'd0, busy_o[d]}, {7'd0, busy});
    chk($sformatf("%s d%0d grant", tag, d), {6'd0, grant_o[d]}, {6'd0, gnt});
    chk($sformatf("%s d%0d sel", tag, d), {5'd0, sel_o[d]}, {5'd0, sel});
    chk($sformatf("%s d%0d mem_wr", tag, d), {7'd0, mem_wr_o[d]}, {7'd0, mw});
    chk($sformatf("%s d%0d ir_wr", tag, d), {7'd0, ir_wr_o[d]}, {7'd0, ir});
    chk($sformatf("%s d%0d mdr_wr", tag, d), {7'd0, mdr_wr_o[d]}, {7'd0, mdr});
    chk($sformatf("%s d%0d done", tag, d), {7'd0, done_o[d]}, {7'd0, done});
    chk($sformatf("%s d%0d exc_bad", tag, d), {7'd0, bad_o[d]}, {7'd0, bad});
  endtask

  task automatic clear_inputs(input int d);
    req_fetch[d] = 0; req_data[d] = 0; data_we[d] = 0; req_reg[d] = 0;
    reg_sel[d] = 0; reg_we[d] = 0; req_exc[d] = 0; exc_cause[d] = 2'b00;
  endtask

  task automatic perturb(input int d);
    data_we[d]   = 1'($urandom);
    reg_sel[d]   = 1'($urandom);
    reg_we[d]    = 1'($urandom);
    exc_cause[d] = 2'($urandom);
    if ($urandom_range(5) == 0) req_fetch[d] = 1;
    if ($urandom_range(5) == 0) req_data[d]  = 1;
    if ($urandom_range(5) == 0) req_reg[d]   = 1;
    if ($urandom_range(7) == 0) req_exc[d]   = 1;
  endtask

  // Called in an IDLE cycle with this cycle's requests already driven; runs one transaction
  // and returns in the IDLE cycle that follows it.
  task automatic run_txn(input int d, input bit rnd, input bit inject_exc, input string tag);
    int          g;
    logic [2:0]  sel;
    bit          wr;
    int          n;
    chk_outs(d, {tag, " idle"}, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    g  = -1;
    wr = 0;
    sel = 3'b000;
    // Highest-priority requester wins; address codes follow the vector numbers 253..255.
    if (req_exc[d]) begin
      g   = 3;
      sel = 3'((253 + ((exc_cause[d] > 2) ? 2 : int'(exc_cause[d]))) - 251);
    end else if (req_data[d]) begin
      g = 1; sel = 3'b001; wr = data_we[d];
    end else if (req_reg[d]) begin
      g = 2; sel = reg_sel[d] ? 3'b110 : 3'b101; wr = reg_we[d];
    end else if (req_fetch[d]) begin
      g = 0;
    end
    if (g < 0) begin
      @(posedge clk); #1;
      return;
    end
    begin
      logic bad;
      bad = (g == 3) && (exc_cause[d] == 2'b11);
      n   = wr ? 2 : 1 + lat_of(d);
      for (int k = 0; k < n; k++) begin
        bit last;
        @(posedge clk); #1;
        last = (k == n - 1);
        chk_outs(d, $sformatf("%s c%0d", tag, k), 1, 2'(g), sel, wr && (k == 0),
                 last && !wr && (g == 0), last && !wr && (g != 0), last, last && bad);
        if (rnd) perturb(d);
        if (inject_exc && k == 0) begin
          req_exc[d] = 1; exc_cause[d] = 2'b00;
        end
      end
    end
    case (g)
      0: req_fetch[d] = 0;
      1: req_data[d]  = 0;
      2: req_reg[d]   = 0;
      default: req_exc[d] = 0;
    endcase
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1;
      clear_inputs(d);
    end
    #1;
    chk_outs(0, "reset", 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    chk_outs(1, "reset", 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    req_fetch[0] = 1;
    @(posedge clk); #1;
    chk_outs(0, "reset held", 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    rst[0] = 0;
    rst[1] = 0;

    // Fetch alone, latency 2.
    run_txn(0, 0, 0, "fetch");

    // Exc, store and fetch together drain in priority order.
    req_fetch[0] = 1; req_data[0] = 1; data_we[0] = 1; req_exc[0] = 1; exc_cause[0] = 2'b01;
    run_txn(0, 0, 0, "pri exc");
    run_txn(0, 0, 0, "pri store");
    run_txn(0, 0, 0, "pri fetch");

    // Register B read, latency 4.
    req_reg[1] = 1; reg_sel[1] = 1; reg_we[1] = 0;
    run_txn(1, 0, 0, "reg B");

    // Illegal exception cause.
    req_exc[0] = 1; exc_cause[0] = 2'b11;
    run_txn(0, 0, 0, "exc bad");

    // Exception raised mid-fetch waits for the fetch to finish.
    req_fetch[0] = 1;
    run_txn(0, 0, 1, "fetch inj");
    run_txn(0, 0, 0, "exc after");

    // Reset in WAIT aborts the load; the held request is re-granted afterwards.
    req_data[1] = 1; data_we[1] = 0;
    @(posedge clk); #1;
    chk_outs(1, "abort access", 1, 2'b01, 3'b001, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_outs(1, "abort wait", 1, 2'b01, 3'b001, 0, 0, 0, 0, 0);
    #2 rst[1] = 1;
    #1;
    chk_outs(1, "abort async", 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_outs(1, "abort held", 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    end
    rst[1] = 0;
    run_txn(1, 0, 0, "regrant");

    // Random traffic with fields and new requests changing mid-access.
    for (int d = 0; d < 2; d++) begin
      clear_inputs(d);
      for (int i = 0; i < 40; i++) begin
        perturb(d);
        run_txn(d, 1, 0, $sformatf("rnd%0d", i));
      end
      clear_inputs(d);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_outs(d, "drain", 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
